// File: rtl/modexp_result_checker.sv
// rtl/modexp_result_checker.sv - recomputes y^e mod n by square-and-multiply and flags a fault when it differs from x mod n
module modexp_result_checker #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] pub_exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             bad_param,
  output logic [WIDTH-1:0] recovered
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, CMP} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   y_r, x_r, e_r, n_r;
  logic [WIDTH-1:0]   acc, b, ref_val;
  logic [IW-1:0]      bit_idx;
  logic [2*WIDTH-1:0] n_wide, mul_acc, mul_sq;
  logic               n_small, last_bit, accept;

  // done is still high in the first IDLE cycle; holding off accept there keeps
  // a request that coincides with the completion pulse from being taken
  assign accept   = (state == IDLE) && start && !done;
  assign n_small  = n_r < WIDTH'(2);
  assign last_bit = bit_idx == IW'(WIDTH - 1);
  assign busy     = state != IDLE;
  assign n_wide   = {{WIDTH{1'b0}}, n_r};
  assign mul_acc  = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, b};
  assign mul_sq   = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = n_small ? CMP : ITER;
      ITER:    if (last_bit) state_next = CMP;
      CMP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      fault     <= 1'b0;
      bad_param <= 1'b0;
      recovered <= '0;
      y_r       <= '0;
      x_r       <= '0;
      e_r       <= '0;
      n_r       <= '0;
      acc       <= '0;
      b         <= '0;
      ref_val   <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_next;
      done  <= (state == CMP);
      case (state)
        IDLE: begin
          if (accept) begin
            y_r       <= result_in;
            x_r       <= base_in;
            e_r       <= pub_exp;
            n_r       <= modulus;
            fault     <= 1'b0;
            bad_param <= 1'b0;
            recovered <= '0;
          end
        end
        LOAD: begin
          // a modulus below 2 skips the divider entirely
          if (n_small) begin
            bad_param <= 1'b1;
            fault     <= 1'b1;
          end else begin
            acc     <= WIDTH'(1);
            b       <= y_r % n_r;
            ref_val <= x_r % n_r;
            bit_idx <= '0;
          end
        end
        ITER: begin
          if (e_r[bit_idx]) acc <= WIDTH'(mul_acc % n_wide);
          b <= WIDTH'(mul_sq % n_wide);
          if (!last_bit) bit_idx <= bit_idx + IW'(1);
        end
        CMP: begin
          if (!bad_param) begin
            recovered <= acc;
            fault     <= (acc != ref_val);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_result_checker.sv
// tb/tb_modexp_result_checker.sv - scoreboard bench for modexp_result_checker against a left-to-right modexp model
module tb_modexp_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] result_in = '0, base_in = '0, pub_exp = '0, modulus = '0;
  logic        busy, done, fault, bad_param;
  logic [31:0] recovered;

  modexp_result_checker #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .result_in(result_in), .base_in(base_in), .pub_exp(pub_exp), .modulus(modulus),
    .busy(busy), .done(done), .fault(fault), .bad_param(bad_param),
    .recovered(recovered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        bp;
    logic [31:0] rec;
    int          due;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int earliest = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // y^e mod n, scanning the exponent from the top bit down
  function automatic logic [31:0] powmod(input logic [31:0] y, input logic [31:0] e, input logic [31:0] n);
    longint unsigned r, bb, nn;
    if (n < 2) return 32'd0;
    nn = {32'd0, n};
    bb = {32'd0, y} % nn;
    r = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * bb) % nn;
    end
    return r[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] y, input logic [31:0] x,
                                 input logic [31:0] e, input logic [31:0] n, input int t);
    exp_t r;
    r.due = (n < 2) ? t + 3 : t + 35;
    r.bp  = (n < 2);
    r.rec = powmod(y, e, n);
    r.f   = (n < 2) ? 1'b1 : (r.rec != (x % n));
    return r;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].due) begin
      check("missing_done", 32'(cyc), 32'(q[0].due));
      void'(q.pop_front());
    end
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        check("done_cycle", 32'(cyc), 32'(ex.due));
        check("fault", {31'd0, fault}, {31'd0, ex.f});
        check("bad_param", {31'd0, bad_param}, {31'd0, ex.bp});
        check("recovered", recovered, ex.rec);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    while (cyc < earliest) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [31:0] y, input logic [31:0] x, input logic [31:0] e,
                       input logic [31:0] n, input bit push, output int t);
    wait_ready();
    result_in = y; base_in = x; pub_exp = e; modulus = n;
    start = 1'b1;
    t = cyc;
    if (push) q.push_back(model(y, x, e, n, t));
    earliest = t + ((n < 2) ? 4 : 36);
    @(posedge clk); #1;
    start = 1'b0;
    result_in = $urandom; base_in = $urandom; pub_exp = $urandom; modulus = $urandom;
  endtask

  int t;
  logic [31:0] ry, rx, re, rn;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_bad_param", {31'd0, bad_param}, 32'd0);
    check("rst_recovered", recovered, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    earliest = cyc;

    issue(32'd65, 32'd2790, 32'd17, 32'd3233, 1'b1, t);
    issue(32'd66, 32'd2790, 32'd17, 32'd3233, 1'b1, t);
    issue(32'h8000_0041, 32'd2790, 32'd17, 32'd3233, 1'b1, t);
    issue(32'd65 + 32'd3233, 32'd6023, 32'd17, 32'd3233, 1'b1, t);
    issue(32'd1234, 32'd1, 32'd0, 32'd3233, 1'b1, t);
    issue(32'd1234, 32'd5, 32'd0, 32'd3233, 1'b1, t);

    for (int k = 0; k < 2; k++) begin
      issue(32'd65, 32'd2790, 32'd17, 32'(k), 1'b1, t);
      @(negedge clk);
      check("bad_busy_t1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("bad_busy_t2", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("bad_busy_t3", {31'd0, busy}, 32'd0);
    end

    // start held high: accepts every WIDTH+4 cycles
    wait_ready();
    result_in = 32'd65; base_in = 32'd2790; pub_exp = 32'd17; modulus = 32'd3233;
    start = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) q.push_back(model(32'd65, 32'd2790, 32'd17, 32'd3233, t + 36 * k));
    while (cyc < t + 80) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    earliest = t + 108;

    // start pulses while busy and in the done cycle are ignored
    issue(32'd65, 32'd2790, 32'd17, 32'd3233, 1'b1, t);
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    result_in = 32'd7; base_in = 32'd9; pub_exp = 32'd3; modulus = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 35) begin
      @(posedge clk); #1;
    end
    modulus = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // reset mid-operation
    issue(32'd66, 32'd2790, 32'd17, 32'd3233, 1'b0, t);
    while (cyc < t + 10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_fault", {31'd0, fault}, 32'd0);
    check("midrst_bad_param", {31'd0, bad_param}, 32'd0);
    check("midrst_recovered", recovered, 32'd0);
    @(posedge clk); #1;
    earliest = cyc;
    issue(32'd65, 32'd2790, 32'd17, 32'd3233, 1'b1, t);

    for (int k = 0; k < 14; k++) begin
      rn = $urandom;
      if (k % 4 == 0) rn = 32'($urandom_range(2, 50000));
      re = $urandom;
      if (k % 5 == 0) re = 32'($urandom_range(0, 70000));
      ry = $urandom;
      rx = ($urandom_range(0, 1) == 1) ? powmod(ry, re, rn) : $urandom;
      issue(ry, rx, re, rn, 1'b1, t);
    end

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
